// File: rtl/ps2_cmd_sequencer.sv
// Purpose: sends a PS/2 command byte plus an optional argument, handles ACK/RESEND/BAT, reports a status, and forwards unsolicited scan codes.
// Latency: ps2_tx_rqst is asserted 1 clk after the command is accepted; rsp_done follows the final device reply by 1 clk.
// Backpressure: cmd_ready is high only in IDLE. Scan codes are single-cycle pulses with no backpressure, and scan bytes that arrive in TX_REQ/TX_WAIT/DONE are dropped.
//
// Ports: clk/rst_n (async active-low); cmd_* client request (valid/ready); rsp_done/rsp_status
// completion pulse; scan_valid/scan_data unsolicited bytes; ps2_* to/from ps2_controller.

package ps2_pkg;
    typedef struct packed {
        logic parity_err;
        logic frame_err;
        logic timeout;
    } flags_t;
endpackage

module ps2_cmd_sequencer #(
    parameter int TIMEOUT_CYC     = 1_000_000,
    parameter int BAT_TIMEOUT_CYC = 40_000_000,
    parameter int MAX_RETRY       = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [7:0]          cmd_byte,
    input  logic                cmd_has_arg,
    input  logic [7:0]          cmd_arg,
    output logic                rsp_done,
    output logic [1:0]          rsp_status,
    output logic                scan_valid,
    output logic [7:0]          scan_data,
    output logic                ps2_en,
    output logic                ps2_tx_rqst,
    output logic [7:0]          ps2_tx_data,
    input  logic                ps2_valid,
    input  logic [7:0]          ps2_rx_data,
    input  ps2_pkg::flags_t     ps2_flags
);

    localparam int MAX_CYC = (TIMEOUT_CYC > BAT_TIMEOUT_CYC) ? TIMEOUT_CYC : BAT_TIMEOUT_CYC;
    localparam int TW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
    localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] BAT_LAST  = TW'(BAT_TIMEOUT_CYC - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_NACK    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_LINK    = 2'b11;

    localparam logic [7:0] B_ACK    = 8'hFA;
    localparam logic [7:0] B_RESEND = 8'hFE;
    localparam logic [7:0] B_ERR    = 8'hFC;
    localparam logic [7:0] B_BAT    = 8'hAA;
    localparam logic [7:0] B_RESET  = 8'hFF;

    typedef enum logic [2:0] {
        IDLE, TX_REQ, TX_WAIT, ACK_WAIT, BAT_WAIT, DONE
    } state_t;

    state_t        state_q, state_n;
    logic [7:0]    cmd_q, cmd_n;
    logic [7:0]    arg_q, arg_n;
    logic          arg_pend_q, arg_pend_n;
    logic [7:0]    tx_dat_q, tx_dat_n;
    logic [RW-1:0] retry_q, retry_n;
    logic [TW-1:0] timer_q, timer_n;
    logic [1:0]    status_q, status_n;
    logic          scan_vld_q, scan_vld_n;
    logic [7:0]    scan_dat_q, scan_dat_n;
    logic          en_q;

    logic rx_ok;
    logic rx_bad;

    assign rx_ok  = ps2_valid && (ps2_flags == '0);
    assign rx_bad = ps2_valid && (ps2_flags != '0);

    always_comb begin
        state_n    = state_q;
        cmd_n      = cmd_q;
        arg_n      = arg_q;
        arg_pend_n = arg_pend_q;
        tx_dat_n   = tx_dat_q;
        retry_n    = retry_q;
        status_n   = status_q;
        scan_vld_n = 1'b0;
        scan_dat_n = scan_dat_q;

        unique case (state_q)
            IDLE: begin
                // Scan forwarding and command acceptance are independent here.
                if (rx_ok) begin
                    scan_vld_n = 1'b1;
                    scan_dat_n = ps2_rx_data;
                end
                if (cmd_valid) begin
                    cmd_n      = cmd_byte;
                    arg_n      = cmd_arg;
                    arg_pend_n = cmd_has_arg;
                    retry_n    = '0;
                    tx_dat_n   = cmd_byte;
                    state_n    = TX_REQ;
                end
            end
            TX_REQ: begin
                state_n = TX_WAIT;
            end
            TX_WAIT: begin
                // ps2_valid here signals the end of the host-to-device transfer.
                if (rx_bad) begin
                    status_n = ST_LINK;
                    state_n  = DONE;
                end else if (rx_ok) begin
                    state_n = ACK_WAIT;
                end else if (timer_q == TO_LAST) begin
                    status_n = ST_TIMEOUT;
                    state_n  = DONE;
                end
            end
            ACK_WAIT: begin
                if (rx_bad) begin
                    status_n = ST_LINK;
                    state_n  = DONE;
                end else if (rx_ok) begin
                    if (ps2_rx_data == B_ACK) begin
                        if (arg_pend_q) begin
                            tx_dat_n   = arg_q;
                            arg_pend_n = 1'b0;
                            retry_n    = '0;
                            state_n    = TX_REQ;
                        end else if (cmd_q == B_RESET) begin
                            state_n = BAT_WAIT;
                        end else begin
                            status_n = ST_OK;
                            state_n  = DONE;
                        end
                    end else if (ps2_rx_data == B_RESEND) begin
                        if (retry_q < RETRY_MAX) begin
                            // Re-send: tx_dat_q still holds the byte being retried.
                            retry_n = retry_q + 1'b1;
                            state_n = TX_REQ;
                        end else begin
                            status_n = ST_NACK;
                            state_n  = DONE;
                        end
                    end else if (ps2_rx_data == B_ERR) begin
                        status_n = ST_NACK;
                        state_n  = DONE;
                    end else begin
                        // Interleaved key data: forward it and keep the timer running.
                        scan_vld_n = 1'b1;
                        scan_dat_n = ps2_rx_data;
                    end
                end else if (timer_q == TO_LAST) begin
                    status_n = ST_TIMEOUT;
                    state_n  = DONE;
                end
            end
            BAT_WAIT: begin
                if (rx_bad) begin
                    status_n = ST_LINK;
                    state_n  = DONE;
                end else if (rx_ok) begin
                    if (ps2_rx_data == B_BAT) begin
                        status_n = ST_OK;
                        state_n  = DONE;
                    end else if (ps2_rx_data == B_ERR) begin
                        status_n = ST_NACK;
                        state_n  = DONE;
                    end else begin
                        scan_vld_n = 1'b1;
                        scan_dat_n = ps2_rx_data;
                    end
                end else if (timer_q == BAT_LAST) begin
                    status_n = ST_TIMEOUT;
                    state_n  = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // The timer restarts on every state change and saturates rather than wrapping.
        if (state_n != state_q) begin
            timer_n = '0;
        end else if (timer_q != '1) begin
            timer_n = timer_q + 1'b1;
        end else begin
            timer_n = timer_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            arg_q      <= '0;
            arg_pend_q <= 1'b0;
            tx_dat_q   <= '0;
            retry_q    <= '0;
            timer_q    <= '0;
            status_q   <= '0;
            scan_vld_q <= 1'b0;
            scan_dat_q <= '0;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_n;
            cmd_q      <= cmd_n;
            arg_q      <= arg_n;
            arg_pend_q <= arg_pend_n;
            tx_dat_q   <= tx_dat_n;
            retry_q    <= retry_n;
            timer_q    <= timer_n;
            status_q   <= status_n;
            scan_vld_q <= scan_vld_n;
            scan_dat_q <= scan_dat_n;
            en_q       <= 1'b1;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign rsp_done    = (state_q == DONE);
    assign rsp_status  = status_q;
    assign scan_valid  = scan_vld_q;
    assign scan_data   = scan_dat_q;
    assign ps2_en      = en_q;
    assign ps2_tx_rqst = (state_q == TX_REQ);
    assign ps2_tx_data = tx_dat_q;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
module tb_ps2_cmd_sequencer;
    import ps2_pkg::*;

    localparam int T_CYC = 2000;
    localparam int B_CYC = 5000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_byte = '0;
    logic       cmd_has_arg = 1'b0;
    logic [7:0] cmd_arg = '0;
    logic       rsp_done;
    logic [1:0] rsp_status;
    logic       scan_valid;
    logic [7:0] scan_data;
    logic       ps2_en;
    logic       ps2_tx_rqst;
    logic [7:0] ps2_tx_data;
    logic       ps2_valid = 1'b0;
    logic [7:0] ps2_rx_data = '0;
    flags_t     ps2_flags = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] exp_tx[$];
    logic [7:0] exp_scan[$];
    logic [1:0] exp_rsp[$];

    ps2_cmd_sequencer #(
        .TIMEOUT_CYC(T_CYC),
        .BAT_TIMEOUT_CYC(B_CYC),
        .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_byte(cmd_byte),
        .cmd_has_arg(cmd_has_arg), .cmd_arg(cmd_arg),
        .rsp_done(rsp_done), .rsp_status(rsp_status),
        .scan_valid(scan_valid), .scan_data(scan_data),
        .ps2_en(ps2_en), .ps2_tx_rqst(ps2_tx_rqst), .ps2_tx_data(ps2_tx_data),
        .ps2_valid(ps2_valid), .ps2_rx_data(ps2_rx_data), .ps2_flags(ps2_flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [7:0] val);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%0h, required no output", name, val);
    endtask

    // Scoreboard monitor: pops one expectation per DUT output event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ps2_tx_rqst) begin
                if (exp_tx.size() == 0) unexpected("tx_unexpected", ps2_tx_data);
                else chk("tx_byte", {24'h0, ps2_tx_data}, {24'h0, exp_tx.pop_front()});
            end
            if (scan_valid) begin
                if (exp_scan.size() == 0) unexpected("scan_unexpected", scan_data);
                else chk("scan_byte", {24'h0, scan_data}, {24'h0, exp_scan.pop_front()});
            end
            if (rsp_done) begin
                if (exp_rsp.size() == 0) unexpected("rsp_unexpected", {6'h0, rsp_status});
                else chk("rsp_status", {30'h0, rsp_status}, {30'h0, exp_rsp.pop_front()});
            end
        end
    end

    // Device side: present one received byte for one cycle.
    task automatic dev_rx(input logic [7:0] b, input flags_t f);
        @(negedge clk);
        ps2_valid   = 1'b1;
        ps2_rx_data = b;
        ps2_flags   = f;
        @(negedge clk);
        ps2_valid   = 1'b0;
        ps2_flags   = '0;
    endtask

    task automatic do_cmd(input logic [7:0] c, input logic ha, input logic [7:0] a);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_before", {31'h0, cmd_ready}, 32'h1);
        cmd_valid   = 1'b1;
        cmd_byte    = c;
        cmd_has_arg = ha;
        cmd_arg     = a;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("cmd_to_rqst_latency", {31'h0, ps2_tx_rqst}, 32'h1);
        chk("cmd_ready_busy", {31'h0, cmd_ready}, 32'h0);
    endtask

    // Wait for a tx request, then report the transfer complete.
    task automatic tx_phase();
        int n = 0;
        while (!ps2_tx_rqst && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ps2_tx_rqst) unexpected("tx_rqst_wait_expired", 8'h00);
        dev_rx(8'h00, '0);
    endtask

    task automatic wait_done(input int budget, output int at);
        int n = 0;
        while (!rsp_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_done) unexpected("rsp_done_wait_expired", 8'h00);
        at = cyc;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, {31'h0, cmd_ready}, 32'h1);
        chk({tag, "_rsp_done"}, {31'h0, rsp_done}, 32'h0);
        chk({tag, "_rsp_status"}, {30'h0, rsp_status}, 32'h0);
        chk({tag, "_scan_valid"}, {31'h0, scan_valid}, 32'h0);
        chk({tag, "_scan_data"}, {24'h0, scan_data}, 32'h0);
        chk({tag, "_ps2_en"}, {31'h0, ps2_en}, 32'h0);
        chk({tag, "_tx_rqst"}, {31'h0, ps2_tx_rqst}, 32'h0);
        chk({tag, "_tx_data"}, {24'h0, ps2_tx_data}, 32'h0);
    endtask

    initial begin
        int t0;
        int t1;
        int seen;
        flags_t par;
        par = flags_t'(3'b100);

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("ps2_en_after_reset", {31'h0, ps2_en}, 32'h1);

        // Unsolicited bytes in IDLE: good one forwarded, flagged one dropped.
        exp_scan.push_back(8'h1C);
        dev_rx(8'h1C, '0);
        dev_rx(8'h55, par);
        @(negedge clk);

        // 0xF4 answered with ACK.
        exp_tx.push_back(8'hF4); exp_rsp.push_back(2'b00);
        do_cmd(8'hF4, 1'b0, 8'h00);
        tx_phase();
        dev_rx(8'hFA, '0);
        wait_done(50, t1);

        // Echo answered with 0xEE: forwarded, then TIMEOUT.
        exp_tx.push_back(8'hEE); exp_scan.push_back(8'hEE); exp_rsp.push_back(2'b10);
        do_cmd(8'hEE, 1'b0, 8'h00);
        tx_phase();
        t0 = cyc;
        dev_rx(8'hEE, '0);
        wait_done(T_CYC + 100, t1);
        chk("echo_timeout_window", {31'h0, ((t1 - t0) >= T_CYC - 1) && ((t1 - t0) <= T_CYC + 1)}, 32'h1);

        // LED command with argument.
        exp_tx.push_back(8'hED); exp_tx.push_back(8'h07); exp_rsp.push_back(2'b00);
        do_cmd(8'hED, 1'b1, 8'h07);
        tx_phase();
        dev_rx(8'hFA, '0);
        tx_phase();
        dev_rx(8'hFA, '0);
        wait_done(50, t1);

        // Two resends then ACK on the command byte, ACK on the argument.
        repeat (3) exp_tx.push_back(8'hF3);
        exp_tx.push_back(8'h20); exp_rsp.push_back(2'b00);
        do_cmd(8'hF3, 1'b1, 8'h20);
        for (int i = 0; i < 2; i++) begin
            tx_phase();
            dev_rx(8'hFE, '0);
        end
        tx_phase();
        dev_rx(8'hFA, '0);
        tx_phase();
        dev_rx(8'hFA, '0);
        wait_done(50, t1);

        // Three resends exhaust the retries: NACK.
        repeat (3) exp_tx.push_back(8'hF3);
        exp_rsp.push_back(2'b01);
        do_cmd(8'hF3, 1'b1, 8'h20);
        for (int i = 0; i < 3; i++) begin
            tx_phase();
            dev_rx(8'hFE, '0);
        end
        wait_done(50, t1);

        // Reset command with BAT.
        exp_tx.push_back(8'hFF); exp_rsp.push_back(2'b00);
        do_cmd(8'hFF, 1'b0, 8'h00);
        tx_phase();
        dev_rx(8'hFA, '0);
        dev_rx(8'hAA, '0);
        wait_done(50, t1);

        // Reset command, BAT never arrives.
        exp_tx.push_back(8'hFF); exp_rsp.push_back(2'b10);
        do_cmd(8'hFF, 1'b0, 8'h00);
        tx_phase();
        dev_rx(8'hFA, '0);
        t0 = cyc;
        wait_done(B_CYC + 100, t1);
        chk("bat_timeout_window", {31'h0, ((t1 - t0) >= B_CYC - 1) && ((t1 - t0) <= B_CYC + 1)}, 32'h1);

        // Scan code interleaved while waiting for the ACK.
        exp_tx.push_back(8'hF4); exp_scan.push_back(8'h32); exp_rsp.push_back(2'b00);
        do_cmd(8'hF4, 1'b0, 8'h00);
        tx_phase();
        dev_rx(8'h32, '0);
        dev_rx(8'hFA, '0);
        wait_done(50, t1);

        // Parity error on the ACK: LINK.
        exp_tx.push_back(8'hF4); exp_rsp.push_back(2'b11);
        do_cmd(8'hF4, 1'b0, 8'h00);
        tx_phase();
        dev_rx(8'hFA, par);
        wait_done(50, t1);

        // Reset during TX_WAIT: outputs return to reset values, no rsp_done.
        exp_tx.push_back(8'hF4);
        do_cmd(8'hF4, 1'b0, 8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_done) seen++;
        end
        chk("no_done_after_reset", seen, 32'h0);
        chk("cmd_ready_after_reset", {31'h0, cmd_ready}, 32'h1);

        chk("exp_tx_left", exp_tx.size(), 32'h0);
        chk("exp_scan_left", exp_scan.size(), 32'h0);
        chk("exp_rsp_left", exp_rsp.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_cmd_sequencer.md
Name: ps2_cmd_sequencer

Overview:
- Sequences host-to-device command transactions over one ps2_controller instance and separates command responses from unsolicited scan codes.
- Takes one command byte, plus an optional argument byte, from a client request interface.
- Issues each byte, waits for ACK (0xFA), re-sends on 0xFE, waits for BAT (0xAA) after a 0xFF reset, then reports a status.
- Sits between the keyboard/mouse application logic and ps2_controller; drives that controller's en, tx_rqst and tx_data.

Parameters:
- TIMEOUT_CYC, 1_000_000, clk cycles allowed for a byte transmission to complete and for the ACK to arrive (20 ms at 50 MHz).
- BAT_TIMEOUT_CYC, 40_000_000, clk cycles allowed for BAT after the ACK to a 0xFF command.
- MAX_RETRY, 2, number of re-sends allowed per byte after a 0xFE response.

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  client command request
- cmd_ready  out  1  sequencer is idle and accepts a command
- cmd_byte  in  8  command code
- cmd_has_arg  in  1  an argument byte follows the command (e.g. 0xED LED, 0xF3 rate)
- cmd_arg  in  8  argument byte
- rsp_done  out  1  one-cycle pulse when a command finishes
- rsp_status  out  2  00 OK, 01 NACK, 10 TIMEOUT, 11 LINK; valid while rsp_done=1
- scan_valid  out  1  one-cycle pulse when an unsolicited byte is forwarded
- scan_data  out  8  forwarded byte; held until the next scan_valid
- ps2_en  out  1  to ps2_controller en
- ps2_tx_rqst  out  1  to ps2_controller tx_rqst
- ps2_tx_data  out  8  to ps2_controller tx_data
- ps2_valid  in  1  from ps2_controller valid
- ps2_rx_data  in  8  from ps2_controller rx_data
- ps2_flags  in  ps2_pkg::flags_t  from ps2_controller; nonzero means the transfer failed

Behaviour:
- Reset values: all outputs 0, except cmd_ready=1. State is IDLE; the retry counter and timer are 0. The command, argument and has_arg registers are cleared.
- Reset mid-transaction returns to IDLE immediately. No rsp_done is generated for the aborted command.
- ps2_en is 1 in every state from the first clk edge after reset deassertion.
- IDLE:
  - cmd_ready=1.
  - cmd_valid=1 latches cmd_byte, cmd_has_arg and cmd_arg, clears retry_cnt, selects the command byte and moves to TX_REQ.
  - Any ps2_valid with ps2_flags==0 forwards ps2_rx_data (scan_valid=1, scan_data registered).
  - A ps2_valid with nonzero flags is dropped silently.
  - If cmd_valid and ps2_valid occur in the same cycle, both are handled: the byte is forwarded and the command is accepted.
- TX_REQ:
  - ps2_tx_data = the selected byte.
  - ps2_tx_rqst=1 for exactly one cycle. The tx_data register holds its value for that cycle and then stays stable until the next TX_REQ.
  - Timer loads 0. Next state is TX_WAIT.
- TX_WAIT:
  - ps2_valid with flags==0 moves to ACK_WAIT with the timer cleared.
  - ps2_valid with flags!=0 finishes with LINK.
  - Timer reaching TIMEOUT_CYC-1 finishes with TIMEOUT.
- ACK_WAIT, on ps2_valid:
  - flags!=0: finish with LINK.
  - 0xFA with the argument still pending: select the argument, clear retry_cnt, go to TX_REQ.
  - 0xFA with no argument pending and the command byte equal to 0xFF: go to BAT_WAIT with the timer cleared.
  - 0xFA otherwise: finish with OK.
  - 0xFE with retry_cnt<MAX_RETRY: increment retry_cnt and go to TX_REQ, re-sending the same byte.
  - 0xFE with retry_cnt==MAX_RETRY: finish with NACK.
  - 0xFC: finish with NACK.
  - Any other byte: forward it as a scan code and stay in ACK_WAIT; the timer does not restart.
  - Timer reaching TIMEOUT_CYC-1 finishes with TIMEOUT.
- BAT_WAIT:
  - 0xAA: finish with OK.
  - 0xFC: finish with NACK.
  - flags!=0: finish with LINK.
  - Other bytes are forwarded as scan codes.
  - Timer reaching BAT_TIMEOUT_CYC-1 finishes with TIMEOUT.
- DONE: lasts one cycle. rsp_done=1 with rsp_status registered. Next state is IDLE; cmd_ready rises in the following cycle.
- Command-latency bound: cmd_valid to ps2_tx_rqst is exactly 1 clk.
- Timer: a single counter of width $clog2(max(TIMEOUT_CYC, BAT_TIMEOUT_CYC)). It is cleared on every state entry and saturates; it does not wrap.
- retry_cnt: width $clog2(MAX_RETRY+1). It resets to 0 per byte, so the command and the argument each get MAX_RETRY re-sends.
- cmd_valid outside IDLE is ignored because cmd_ready=0. The client must hold its request until accepted.

Test Plan:
- Echo with no argument: cmd 0xEE; device answers 0xEE instead of 0xFA → byte forwarded, TIMEOUT after TIMEOUT_CYC. Repeat with cmd 0xF4 answered 0xFA → rsp_done with status 00 and exactly one tx_rqst pulse.
- LED command: cmd 0xED, arg 0x07; device ACKs both bytes → two tx_rqst pulses carrying 0xED then 0x07, status 00, no scan_valid.
- Resend: device returns 0xFE twice and then 0xFA for cmd 0xF3/arg 0x20 → three transmissions of 0xF3, status 00. Returning 0xFE three times → status 01.
- Reset command: cmd 0xFF; device sends 0xFA then 0xAA → status 00. Suppressing BAT (BAT_TIMEOUT_CYC overridden to 5000) → status 10 at 5000±1 cycles after the ACK.
- Scan interleave: device emits 0x1C in IDLE and 0x32 during ACK_WAIT → two scan_valid pulses with those bytes; the command still completes with status 00.
- Faults: parity error injected on the ACK → status 11. rst_n asserted during TX_WAIT → all outputs at reset values, cmd_ready=1 after release, no rsp_done.
